// File: rtl/uart_boot_loader_pkg.sv
// uart_boot_loader_pkg: shared state encodings and constants for the UART boot loader.
package uart_boot_loader_pkg;
   typedef enum logic [2:0] {HDR0, HDR1, DATA, WRITE, DONE} state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   localparam logic [3:0] FULL_WORD = 4'hF;
   localparam int DEFAULT_CLKS_PER_BIT = 868;
endpackage

// File: rtl/uart_boot_loader_rx.sv
// uart_rx: 8N1 receiver with 2-FF synchronizer; pulses byte_valid or frame_err once per frame.
module uart_rx
   import uart_boot_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err
);
   localparam int W = $clog2(CLKS_PER_BIT);
   localparam logic [W-1:0] FULL = W'(CLKS_PER_BIT - 1);
   localparam logic [W-1:0] HALF = W'(CLKS_PER_BIT / 2 - 1);
   rx_state_t rs, rs_n;
   logic [1:0] sync;
   logic prev, tick;
   logic [W-1:0] cnt;
   logic [2:0] bit_cnt;
   always_comb begin
      tick = cnt == (rs == RX_START ? HALF : FULL);
      rs_n = rs;
      case (rs)
         RX_IDLE:  rs_n = (prev && !sync[1]) ? RX_START : RX_IDLE;
         RX_START: rs_n = tick ? (sync[1] ? RX_IDLE : RX_DATA) : RX_START;
         RX_DATA:  rs_n = (tick && bit_cnt == 3'd7) ? RX_STOP : RX_DATA;
         RX_STOP:  rs_n = tick ? RX_IDLE : RX_STOP;
         default:  rs_n = RX_IDLE;
      endcase
   end
   // bit_cnt wraps back to 0 after the eighth data bit, so it needs no explicit clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rs <= RX_IDLE;
         sync <= 2'b11;
         prev <= 1'b1;
         cnt <= '0;
         bit_cnt <= '0;
         byte_data <= '0;
         byte_valid <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rs <= rs_n;
         sync <= {sync[0], rx};
         prev <= sync[1];
         cnt <= (rs == RX_IDLE || tick) ? '0 : cnt + 1'b1;
         if (rs == RX_DATA && tick) begin
            byte_data <= {sync[1], byte_data[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
         end
         byte_valid <= rs == RX_STOP && tick && sync[1];
         frame_err <= rs == RX_STOP && tick && !sync[1];
      end
   end
endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: loads a UART-framed word image into instruction memory,
// holding the core in reset until the last word is written.
module uart_boot_loader
   import uart_boot_loader_pkg::*;
#(
   parameter int ADDR_BITS = 10,
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   input  logic                 reload,
   output logic [3:0]           mem_w_enb,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [31:0]          mem_w_data,
   output logic                 core_rst,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);
   localparam logic [16:0] DEPTH = 17'(1 << (ADDR_BITS - 2));
   state_t state, state_n;
   logic byte_valid, frame_err;
   logic [7:0] byte_data;
   logic [16:0] n, word_idx, hdr_n;
   logic [1:0] bidx;
   logic [31:0] word;
   assign hdr_n = {1'b0, byte_data, n[7:0]};
   assign mem_w_enb = state == WRITE ? FULL_WORD : 4'h0;
   assign mem_addr = {word_idx[ADDR_BITS-3:0], 2'b00};
   assign mem_w_data = word;
   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk(clk),
      .rst(rst),
      .rx(rx),
      .byte_valid(byte_valid),
      .byte_data(byte_data),
      .frame_err(frame_err)
   );
   always_comb begin
      state_n = state;
      case (state)
         HDR0:    state_n = byte_valid ? HDR1 : HDR0;
         HDR1:    state_n = !byte_valid ? HDR1 : (hdr_n == '0 ? DONE : DATA);
         DATA:    state_n = (byte_valid && bidx == 2'd3) ? WRITE : DATA;
         WRITE:   state_n = (word_idx + 17'd1 == n) ? DONE : DATA;
         DONE:    state_n = reload ? HDR0 : DONE;
         default: state_n = HDR0;
      endcase
   end
   // status outputs are registered from the next state so they align with the state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= HDR0;
         n <= '0;
         word_idx <= '0;
         bidx <= '0;
         word <= '0;
         err <= 1'b0;
         core_rst <= 1'b1;
         busy <= 1'b1;
         done <= 1'b0;
      end else begin
         state <= state_n;
         core_rst <= state_n != DONE;
         busy <= state_n != DONE;
         done <= state_n == DONE;
         if (frame_err) err <= 1'b1;
         case (state)
            HDR0: if (byte_valid) n[7:0] <= byte_data;
            HDR1: if (byte_valid) begin
               n <= hdr_n > DEPTH ? DEPTH : hdr_n;
               if (hdr_n > DEPTH) err <= 1'b1;
            end
            DATA: if (byte_valid) begin
               word[8*bidx +: 8] <= byte_data;
               bidx <= bidx + 1'b1;
            end
            WRITE: begin
               word_idx <= word_idx + 17'd1;
               bidx <= '0;
            end
            DONE: if (reload) begin
               err <= 1'b0;
               word_idx <= '0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: randomized frames against a queue-based image model; a monitor scores every memory write.
module tb_uart_boot_loader;
   localparam int CPB = 8;
   localparam int AB = 4;
   localparam int DEPTH = 4;
   typedef struct {
      logic [AB-1:0] addr;
      logic [31:0] data;
   } wr_t;
   logic clk = 0, rst = 1, rx = 1, reload = 0;
   logic [3:0] mem_w_enb;
   logic [AB-1:0] mem_addr;
   logic [31:0] mem_w_data;
   logic core_rst, busy, done, err;
   int checks = 0, errors = 0;
   wr_t exp_q[$];
   logic [7:0] stim[$];
   logic chk_final = 0;

   uart_boot_loader #(.ADDR_BITS(AB), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk),
      .rst(rst),
      .rx(rx),
      .reload(reload),
      .mem_w_enb(mem_w_enb),
      .mem_addr(mem_addr),
      .mem_w_data(mem_w_data),
      .core_rst(core_rst),
      .busy(busy),
      .done(done),
      .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      wr_t e;
      if (chk_final) begin
         chk("final_align {done,core_rst}", {30'd0, done, core_rst}, 32'd2);
         chk_final = 0;
      end
      if (mem_w_enb !== 4'h0) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %h data %h enb %h", mem_addr, mem_w_data, mem_w_enb);
         end else begin
            e = exp_q.pop_front();
            chk("wr_enb", 32'(mem_w_enb), 32'hF);
            chk("wr_addr", 32'(mem_addr), 32'(e.addr));
            chk("wr_data", mem_w_data, e.data);
            chk("wr_align {done,core_rst}", {30'd0, done, core_rst}, 32'd1);
            chk_final = exp_q.size() == 0;
         end
      end
   end

   task automatic chk_reset_vals();
      chk("rst core_rst", 32'(core_rst), 1);
      chk("rst busy", 32'(busy), 1);
      chk("rst done", 32'(done), 0);
      chk("rst err", 32'(err), 0);
      chk("rst mem_w_enb", 32'(mem_w_enb), 0);
      chk("rst mem_addr", 32'(mem_addr), 0);
      chk("rst mem_w_data", mem_w_data, 0);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = f[i];
         repeat (CPB) @(negedge clk);
      end
      rx = 1;
      repeat (2 * CPB) @(negedge clk);
   endtask

   task automatic pulse_reload();
      @(negedge clk) reload = 1;
      @(negedge clk) reload = 0;
   endtask

   task automatic do_reload();
      pulse_reload();
      chk("reload core_rst", 32'(core_rst), 1);
      chk("reload err", 32'(err), 0);
      chk("reload done", 32'(done), 0);
      chk("reload busy", 32'(busy), 1);
   endtask

   task automatic fill_stim(input int cnt);
      stim.delete();
      for (int i = 0; i < cnt; i++) stim.push_back(8'($urandom));
   endtask

   // Model: drop the bad-stop byte, clamp N to DEPTH, pack survivors 4 per word little-endian.
   task automatic load(input int n, input int bad, input int rl);
      logic [7:0] good[$];
      wr_t w;
      int eff;
      eff = n > DEPTH ? DEPTH : n;
      foreach (stim[i]) if (i != bad) good.push_back(stim[i]);
      for (int k = 0; k < eff; k++) begin
         w.addr = AB'(k * 4);
         w.data = {good[4*k+3], good[4*k+2], good[4*k+1], good[4*k]};
         exp_q.push_back(w);
      end
      send_byte(8'(n), 1'b1);
      send_byte(8'(n >> 8), 1'b1);
      foreach (stim[i]) begin
         send_byte(stim[i], i != bad);
         if (i == rl) pulse_reload();
      end
      for (int c = 0; c < 500 && done !== 1'b1; c++) @(negedge clk);
      chk("load done", 32'(done), 1);
      chk("load core_rst", 32'(core_rst), 0);
      chk("load busy", 32'(busy), 0);
      chk("load err", 32'(err), 32'((n > DEPTH) || (bad >= 0)));
      chk("load pending writes", 32'(exp_q.size()), 0);
   endtask

   initial begin
      int n, bad, lim;
      repeat (3) @(negedge clk);
      chk_reset_vals();
      rst = 0;
      @(negedge clk);
      stim = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      load(2, -1, -1);
      do_reload();
      stim.delete();
      load(0, -1, -1);
      do_reload();
      fill_stim(24);
      load(6, -1, -1);
      do_reload();
      fill_stim(5);
      load(1, 1, -1);
      do_reload();
      rx = 0;
      repeat (3) @(negedge clk);
      rx = 1;
      repeat (5 * CPB) @(negedge clk);
      chk("glitch err", 32'(err), 0);
      chk("glitch busy", 32'(busy), 1);
      fill_stim(4);
      load(1, -1, -1);
      do_reload();
      fill_stim(8);
      load(2, -1, 1);
      do_reload();
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'hA5, 1'b1);
      send_byte(8'h5A, 1'b1);
      @(negedge clk);
      #2 rst = 1;
      #1 chk_reset_vals();
      @(negedge clk) rst = 0;
      @(negedge clk);
      fill_stim(4);
      load(1, -1, -1);
      for (int it = 0; it < 6; it++) begin
         do_reload();
         n = $urandom_range(0, 6);
         lim = (n > DEPTH ? DEPTH : n) * 4;
         bad = (n > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, lim - 1)) : -1;
         fill_stim(n * 4 + (bad >= 0 ? 1 : 0));
         load(n, bad, -1);
      end
      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
